// File: rtl/sparse_row_streamer_pkg.sv
// Shared defaults and FSM state encoding for the sparse activation row streamer.
package sparse_row_streamer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ROW_W      = 16;
  localparam int DEF_NUM_ROWS   = 16;
  localparam int DEF_ACT_DEPTH  = 256;
  localparam int DEF_REP_W      = 3;

  // Encoding is visible on the debug state port, so values are pinned.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/sparse_row_streamer_lsb_prienc.sv
// Lowest-set-bit priority encoder with popcount for a row flag mask.
module sparse_row_streamer_lsb_prienc #(
  parameter int W = 16,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0] vec,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic [IW:0]   cnt
);

  // Scan from the top down so the last hit is the lowest set bit; count ones.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    idx = '0;
    any = 1'b0;
    cnt = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
    for (int i = 0; i < W; i++) begin
      cnt = cnt + (IW + 1)'(vec[i]);
    end
  end

endmodule

// File: rtl/sparse_row_streamer.sv
// Buffers row flag bitmaps and zero-compressed activations, then streams each
// row's nonzero values with their column index over valid/ready, with optional
// per-row replay and explicit zero-row signalling.
module sparse_row_streamer
  import sparse_row_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROW_W      = DEF_ROW_W,
  parameter int NUM_ROWS   = DEF_NUM_ROWS,
  parameter int ACT_DEPTH  = DEF_ACT_DEPTH,
  parameter int REP_W      = DEF_REP_W,
  localparam int COL_W     = $clog2(ROW_W),
  localparam int ROWI_W    = $clog2(NUM_ROWS),
  localparam int ACT_AW    = $clog2(ACT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req_flag,
  input  logic [ROW_W-1:0]      wr_data_flag,
  input  logic                  wr_req_act,
  input  logic [DATA_WIDTH-1:0] wr_data_act,
  input  logic                  mode,
  input  logic [REP_W-1:0]      cfg_replay,
  input  logic                  start,
  input  logic                  out_ready,
  input  logic                  row_cal_done,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [COL_W-1:0]      out_col,
  output logic [ROWI_W-1:0]     row_index,
  output logic [COL_W:0]        row_val_num,
  output logic [REP_W-1:0]      pass_index,
  output logic                  zero_flag,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err,
  output logic [2:0]            state
);

  logic [ROW_W-1:0]      flag_mem [NUM_ROWS];
  logic [DATA_WIDTH-1:0] act_mem  [ACT_DEPTH];

  state_t                state_q;
  logic [ROWI_W:0]       flag_wr_ptr;
  logic [ACT_AW:0]       act_wr_ptr;
  logic [ACT_AW-1:0]     rd_ptr, row_base, rd_next, act_rd_addr;
  logic [ROW_W-1:0]      mask, pe_vec, flag_rd;
  logic [DATA_WIDTH-1:0] act_rd;
  logic [COL_W-1:0]      pe_idx;
  logic                  pe_any;
  logic [COL_W:0]        pe_cnt;
  logic                  mode_l;
  logic [REP_W-1:0]      rep_l, eff_rep;
  logic                  flag_full, act_full, flag_we, act_we, wr_drop;
  logic                  more_passes, last_row;

  assign flag_full = (flag_wr_ptr == (ROWI_W + 1)'(NUM_ROWS));
  assign act_full  = (act_wr_ptr == (ACT_AW + 1)'(ACT_DEPTH));
  assign flag_we   = wr_req_flag && (state_q == ST_IDLE) && !flag_full;
  assign act_we    = wr_req_act && (state_q == ST_IDLE) && !act_full;
  assign wr_drop   = (wr_req_flag && !flag_we) || (wr_req_act && !act_we);

  // In STREAM the registered outputs are refilled from the next activation, so
  // the single read port looks one word ahead; in HDR it reads the row's first word.
  assign rd_next     = (rd_ptr == ACT_AW'(ACT_DEPTH - 1)) ? '0 : rd_ptr + ACT_AW'(1);
  assign act_rd_addr = (state_q == ST_STREAM) ? rd_next : rd_ptr;
  assign act_rd      = act_mem[act_rd_addr];
  assign flag_rd     = flag_mem[row_index];

  // The encoder sees the fresh row bitmap in HDR and the remaining mask afterwards.
  assign pe_vec = (state_q == ST_HDR) ? flag_rd : mask;

  assign eff_rep     = (rep_l == '0) ? REP_W'(1) : rep_l;
  assign more_passes = mode_l && (pass_index < eff_rep - REP_W'(1));
  assign last_row    = ({1'b0, row_index} + (ROWI_W + 1)'(1)) == flag_wr_ptr;
  assign state       = state_q;

  sparse_row_streamer_lsb_prienc #(.W(ROW_W)) u_prienc (
    .vec (pe_vec),
    .idx (pe_idx),
    .any (pe_any),
    .cnt (pe_cnt)
  );

  // Buffer writes into the flag and activation arrays.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays have no reset; contents are only read after being written.
    if (flag_we) flag_mem[flag_wr_ptr[ROWI_W-1:0]] <= wr_data_flag;
    if (act_we)  act_mem[act_wr_ptr[ACT_AW-1:0]]   <= wr_data_act;
  end

  // Control FSM with all outputs registered; also owns the write pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
      state_q     <= ST_IDLE;
      flag_wr_ptr <= '0;
      act_wr_ptr  <= '0;
      rd_ptr      <= '0;
      row_base    <= '0;
      mask        <= '0;
      mode_l      <= 1'b0;
      rep_l       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_col     <= '0;
      row_index   <= '0;
      row_val_num <= '0;
      pass_index  <= '0;
      zero_flag   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      zero_flag <= 1'b0;
      done      <= 1'b0;
      if (flag_we) flag_wr_ptr <= flag_wr_ptr + (ROWI_W + 1)'(1);
      if (act_we)  act_wr_ptr  <= act_wr_ptr + (ACT_AW + 1)'(1);
      if (start && (state_q == ST_IDLE)) wr_err <= 1'b0;
      if (wr_drop) wr_err <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (flag_wr_ptr != '0) begin
              mode_l  <= mode;
              rep_l   <= cfg_replay;
              busy    <= 1'b1;
              state_q <= ST_HDR;
            end else begin
              done    <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_HDR: begin
          row_val_num <= pe_cnt;
          if (!pe_any) begin
            mask      <= '0;
            zero_flag <= 1'b1;
            state_q   <= ST_WAIT;
          end else begin
            out_valid <= 1'b1;
            out_col   <= pe_idx;
            out_data  <= act_rd;
            mask      <= pe_vec & (pe_vec - ROW_W'(1));
            state_q   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // mask holds the columns still to send after the beat currently presented.
          if (out_ready) begin
            rd_ptr <= rd_next;
            if (pe_any) begin
              out_col  <= pe_idx;
              out_data <= act_rd;
              mask     <= mask & (mask - ROW_W'(1));
            end else begin
              out_valid <= 1'b0;
              state_q   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (row_cal_done) begin
            if (more_passes) begin
              pass_index <= pass_index + REP_W'(1);
              rd_ptr     <= row_base;
              state_q    <= ST_HDR;
            end else begin
              pass_index <= '0;
              row_base   <= rd_ptr;
              if (last_row) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                row_index <= row_index + ROWI_W'(1);
                state_q   <= ST_HDR;
              end
            end
          end
        end
        ST_DONE: begin
          flag_wr_ptr <= '0;
          act_wr_ptr  <= '0;
          rd_ptr      <= '0;
          row_base    <= '0;
          row_index   <= '0;
          row_val_num <= '0;
          pass_index  <= '0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_row_streamer.sv
// Directed bench for sparse_row_streamer with hand-computed beat sequences.
module tb_sparse_row_streamer;
  import sparse_row_streamer_pkg::*;

  localparam int DW = 8, RW = 16, NR = 4, AD = 256, RPW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req_flag, wr_req_act, mode, start, out_ready, row_cal_done;
  logic [RW-1:0] wr_data_flag;
  logic [DW-1:0] wr_data_act;
  logic [RPW-1:0] cfg_replay;
  logic          out_valid, zero_flag, busy, done, wr_err;
  logic [DW-1:0] out_data;
  logic [3:0]    out_col;
  logic [1:0]    row_index;
  logic [4:0]    row_val_num;
  logic [RPW-1:0] pass_index;
  logic [2:0]    state;

  int errors = 0;
  int checks = 0;

  sparse_row_streamer #(
    .DATA_WIDTH(DW), .ROW_W(RW), .NUM_ROWS(NR), .ACT_DEPTH(AD), .REP_W(RPW)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_req_flag(wr_req_flag), .wr_data_flag(wr_data_flag),
    .wr_req_act(wr_req_act), .wr_data_act(wr_data_act),
    .mode(mode), .cfg_replay(cfg_replay), .start(start),
    .out_ready(out_ready), .row_cal_done(row_cal_done),
    .out_valid(out_valid), .out_data(out_data), .out_col(out_col),
    .row_index(row_index), .row_val_num(row_val_num), .pass_index(pass_index),
    .zero_flag(zero_flag), .busy(busy), .done(done), .wr_err(wr_err),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_flag(input logic [RW-1:0] v);
    wr_req_flag = 1'b1; wr_data_flag = v;
    tick();
    wr_req_flag = 1'b0;
  endtask

  task automatic wr_act(input logic [DW-1:0] v);
    wr_req_act = 1'b1; wr_data_act = v;
    tick();
    wr_req_act = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input string tag, input int col, input int data);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_col"}, out_col, col);
    check({tag, "_data"}, out_data, data);
  endtask

  task automatic cal_done();
    row_cal_done = 1'b1;
    tick();
    row_cal_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    wr_req_flag = 0; wr_req_act = 0; wr_data_flag = '0; wr_data_act = '0;
    mode = 0; cfg_replay = '0; start = 0; out_ready = 1; row_cal_done = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_col", out_col, 0);
    check("rst_row", row_index, 0);
    check("rst_rvn", row_val_num, 0);
    check("rst_pass", pass_index, 0);
    check("rst_zero", zero_flag, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrerr", wr_err, 0);
    check("rst_state", state, ST_IDLE);
    reset = 1'b1;
    tick();

    // Test 1: single row 0x0085, no backpressure.
    wr_flag(16'h0085); wr_act(8'd11); wr_act(8'd22); wr_act(8'd33);
    pulse_start();
    check("t1_hdr_state", state, ST_HDR);
    check("t1_hdr_valid", out_valid, 0);
    check("t1_busy", busy, 1);
    tick(); beat("t1_b0", 0, 11);
    check("t1_rvn", row_val_num, 3);
    tick(); beat("t1_b1", 2, 22);
    tick(); beat("t1_b2", 7, 33);
    tick();
    check("t1_end_valid", out_valid, 0);
    check("t1_wait", state, ST_WAIT);
    repeat (3) tick();
    check("t1_still_wait", state, ST_WAIT);
    cal_done();
    check("t1_done_state", state, ST_DONE);
    check("t1_done", done, 1);
    check("t1_busy_off", busy, 0);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_idle", state, ST_IDLE);

    // Test 3: backpressure on beat 2 of the same row.
    wr_flag(16'h0085); wr_act(8'd11); wr_act(8'd22); wr_act(8'd33);
    pulse_start();
    tick(); beat("t3_b0", 0, 11);
    tick(); beat("t3_b1", 2, 22);
    out_ready = 1'b0;
    tick(); beat("t3_hold1", 2, 22);
    tick(); beat("t3_hold2", 2, 22);
    out_ready = 1'b1;
    tick(); beat("t3_b2", 7, 33);
    tick();
    check("t3_wait", state, ST_WAIT);
    cal_done();
    check("t3_done", done, 1);
    tick();

    // Test 2: zero row between two rows.
    wr_flag(16'h0003); wr_flag(16'h0000); wr_flag(16'h8000);
    wr_act(8'd1); wr_act(8'd2); wr_act(8'd3);
    pulse_start();
    tick(); beat("t2_r0b0", 0, 1);
    check("t2_r0_rvn", row_val_num, 2);
    tick(); beat("t2_r0b1", 1, 2);
    tick();
    check("t2_r0_wait", state, ST_WAIT);
    cal_done();
    check("t2_r1_hdr", state, ST_HDR);
    check("t2_r1_idx", row_index, 1);
    tick();
    check("t2_zero", zero_flag, 1);
    check("t2_zero_valid", out_valid, 0);
    check("t2_zero_rvn", row_val_num, 0);
    check("t2_zero_wait", state, ST_WAIT);
    tick();
    check("t2_zero_pulse", zero_flag, 0);
    check("t2_zero_novalid", out_valid, 0);
    cal_done();
    check("t2_r2_idx", row_index, 2);
    tick(); beat("t2_r2b0", 15, 3);
    check("t2_r2_rvn", row_val_num, 1);
    tick();
    check("t2_r2_wait", state, ST_WAIT);
    cal_done();
    check("t2_done", done, 1);
    tick();

    // Test 4: replay mode, 3 passes over 2 rows; mode inputs changed after start.
    mode = 1'b1; cfg_replay = 3'd3;
    wr_flag(16'h0011); wr_flag(16'h0100);
    wr_act(8'd5); wr_act(8'd6); wr_act(8'd7);
    pulse_start();
    mode = 1'b0; cfg_replay = 3'd0;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 3; p++) begin
        tick();
        check($sformatf("t4_r%0dp%0d_pass", r, p), pass_index, p);
        check($sformatf("t4_r%0dp%0d_row", r, p), row_index, r);
        if (r == 0) begin
          beat($sformatf("t4_r0p%0d_b0", p), 0, 5);
          tick();
          beat($sformatf("t4_r0p%0d_b1", p), 4, 6);
        end else begin
          beat($sformatf("t4_r1p%0d_b0", p), 8, 7);
        end
        tick();
        check($sformatf("t4_r%0dp%0d_wait", r, p), state, ST_WAIT);
        cal_done();
        if (r == 1 && p == 2) begin
          check("t4_done_state", state, ST_DONE);
          check("t4_done", done, 1);
        end else begin
          check($sformatf("t4_r%0dp%0d_next", r, p), state, ST_HDR);
        end
      end
    end
    tick();

    // Test 5: overflow, write while busy, start while busy, start clears wr_err.
    for (int i = 0; i < 4; i++) wr_flag(16'h0001);
    check("t5_no_err", wr_err, 0);
    wr_flag(16'hFFFF);
    check("t5_overflow_err", wr_err, 1);
    wr_act(8'd10); wr_act(8'd20); wr_act(8'd30); wr_act(8'd40);
    pulse_start();
    check("t5_start_clr", wr_err, 0);
    check("t5_hdr", state, ST_HDR);
    tick(); beat("t5_r0", 0, 10);
    wr_flag(16'h0002);
    check("t5_busy_err", wr_err, 1);
    check("t5_r0_wait", state, ST_WAIT);
    pulse_start();
    check("t5_start_ignored", state, ST_WAIT);
    check("t5_still_busy", busy, 1);
    for (int r = 1; r < 4; r++) begin
      cal_done();
      check($sformatf("t5_r%0d_hdr", r), state, ST_HDR);
      check($sformatf("t5_r%0d_idx", r), row_index, r);
      tick(); beat($sformatf("t5_r%0d", r), 0, (r + 1) * 10);
      tick();
      check($sformatf("t5_r%0d_wait", r), state, ST_WAIT);
    end
    cal_done();
    check("t5_done_4rows", state, ST_DONE);
    tick();
    check("t5_err_sticky", wr_err, 1);
    pulse_start();
    check("t5_empty_done_state", state, ST_DONE);
    check("t5_empty_done", done, 1);
    check("t5_err_cleared", wr_err, 0);
    tick();

    // Test 6: reset mid-STREAM, then a fresh load streams from row 0.
    wr_flag(16'h000F);
    wr_act(8'd1); wr_act(8'd2); wr_act(8'd3); wr_act(8'd4);
    pulse_start();
    tick(); beat("t6_pre_b0", 0, 1);
    tick(); beat("t6_pre_b1", 1, 2);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_col", out_col, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rvn", row_val_num, 0);
    check("t6_rst_state", state, ST_IDLE);
    reset = 1'b1;
    tick();
    wr_flag(16'h0006); wr_act(8'd50); wr_act(8'd60);
    pulse_start();
    tick(); beat("t6_b0", 1, 50);
    check("t6_row", row_index, 0);
    check("t6_rvn", row_val_num, 2);
    tick(); beat("t6_b1", 2, 60);
    tick();
    check("t6_wait", state, ST_WAIT);
    cal_done();
    check("t6_done", done, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
